// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus -> memory port arbiter.
package mem_bus_arbiter_pkg;

   localparam logic [1:0] MSIZE_WORD = 2'd2;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } mem_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } mem_resp_t;

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t IDLE = 2'd0;
   localparam arb_state_t ADDR = 2'd1;
   localparam arb_state_t DATA = 2'd2;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_t;

endpackage

// File: rtl/mem_bus_arbiter_priority.sv
// Next-owner pick: dbus first, but after MAX_D_STREAK consecutive dbus wins
// over a waiting ibus the next grant goes to ibus.
module mem_bus_arbiter_priority
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic       ivalid_i,
   input  logic       dvalid_i,
   input  logic [3:0] streak_i,
   output arb_owner_t winner_o,
   output logic [3:0] streak_o
);

   // winner and streak value to load if this pick is taken
   always_comb begin
      winner_o = OWN_NONE;
      streak_o = streak_i;
      if (ivalid_i && dvalid_i) begin
         if (streak_i >= 4'(MAX_D_STREAK)) begin
            winner_o = OWN_I;
            streak_o = 4'd0;
         end else begin
            winner_o = OWN_D;
            streak_o = streak_i + 4'd1;
         end
      end else if (dvalid_i) begin
         winner_o = OWN_D;
         streak_o = 4'd0;
      end else if (ivalid_i) begin
         winner_o = OWN_I;
         streak_o = 4'd0;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (ibus) and load/store (dbus).
//
//   state | meaning
//   IDLE  | no transfer; pick a winner from this cycle's valids
//   ADDR  | owner's request driven on mreq, waiting for addr_ok
//   DATA  | address accepted, mreq idle, waiting for data_ok
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  ibus_req_t  ireq_i,
   output ibus_resp_t iresp_o,
   input  dbus_req_t  dreq_i,
   output dbus_resp_t dresp_o,
   output mem_req_t   mreq_o,
   input  mem_resp_t  mresp_i
);

   arb_state_t state_q, state_d;
   arb_owner_t owner_q, owner_d, win;
   logic [3:0] streak_q, streak_d, streak_win;
   logic       owner_valid;
   mem_req_t   owner_req;
   logic       addr_ok, data_ok;

   mem_bus_arbiter_priority #(.MAX_D_STREAK(MAX_D_STREAK)) u_priority (
      .ivalid_i (ireq_i.valid),
      .dvalid_i (dreq_i.valid),
      .streak_i (streak_q),
      .winner_o (win),
      .streak_o (streak_win)
   );

   // owner's request as it would appear on the memory port
   always_comb begin
      owner_req   = '0;
      owner_valid = 1'b0;
      case (owner_q)
         OWN_I: begin
            owner_valid    = ireq_i.valid;
            owner_req.valid = ireq_i.valid;
            owner_req.addr = ireq_i.addr;
            owner_req.size = MSIZE_WORD;
         end
         OWN_D: begin
            owner_valid      = dreq_i.valid;
            owner_req.valid  = dreq_i.valid;
            owner_req.addr   = dreq_i.addr;
            owner_req.size   = dreq_i.size;
            owner_req.strobe = dreq_i.strobe;
            owner_req.data   = dreq_i.data;
         end
         default: ;
      endcase
   end

   // transfer sequencing; data_ok in ADDR also implies the address was taken
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      case (state_q)
         IDLE: begin
            if (win != OWN_NONE) begin
               state_d  = ADDR;
               owner_d  = win;
               streak_d = streak_win;
            end
         end
         ADDR: begin
            if (!owner_valid || mresp_i.data_ok) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
            end else if (mresp_i.addr_ok) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (mresp_i.data_ok) begin
               state_d = IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   // state, owner and streak registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         owner_q  <= OWN_NONE;
         streak_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   // request mux and response demux; an aborted address phase returns nothing
   always_comb begin
      mreq_o  = '0;
      iresp_o = '0;
      dresp_o = '0;
      addr_ok = (state_q == ADDR) && owner_valid && mresp_i.addr_ok;
      data_ok = (((state_q == ADDR) && owner_valid) || (state_q == DATA)) && mresp_i.data_ok;
      if ((state_q == ADDR) && owner_valid) begin
         mreq_o = owner_req;
      end
      if (owner_q == OWN_I) begin
         iresp_o.addr_ok = addr_ok;
         iresp_o.data_ok = data_ok;
         iresp_o.data    = mresp_i.data;
      end else if (owner_q == OWN_D) begin
         dresp_o.addr_ok = addr_ok;
         dresp_o.data_ok = data_ok;
         dresp_o.data    = mresp_i.data;
      end
   end

endmodule
